// File: rtl/inst_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/return, decode
// handshake, redirect and occupancy.
//   master : the fetch queue (drives requests, head entry, count)
//   slave  : the environment (memory + decode)
interface inst_fetch_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [CW-1:0]         count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, count,
    input  imem_data, redirect, redirect_addr, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, count,
    output imem_data, redirect, redirect_addr, inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue.
// Owns the fetch PC, issues reads to a synchronous instruction memory
// (data returns one cycle after the request), buffers returned
// instructions tagged with their PC and hands them to decode over a
// valid/ready handshake. A redirect flushes the queue and refetches.
// Ports:
//   CLK  - clock, all state on posedge
//   RST  - asynchronous active-low reset
//   ifq  - inst_fetch_queue_if.master: imem_req/imem_addr/imem_data,
//          redirect/redirect_addr, inst_valid/inst_ready/inst_data/
//          inst_pc, count
module inst_fetch_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 4
) (
  input  logic               CLK,
  input  logic               RST,
  inst_fetch_queue_if.master ifq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic                  inflight;
  logic                  cancel;

  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count_q;

  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_pc;

  logic                  pop;
  logic                  push;
  logic                  req;
  logic [CW:0]           occ;
  logic [CW-1:0]         keep_cnt;
  logic [PW-1:0]         rd_next;
  logic                  head_valid_n;
  logic [DATA_WIDTH-1:0] head_data_n;
  logic [ADDR_WIDTH-1:0] head_pc_n;

  assign pop  = head_valid & ifq.inst_ready;
  // cancel marks a return belonging to a request issued before a redirect
  assign push = inflight & ~cancel;

  // Credit check counts the in-flight return as already occupying a slot,
  // so the queue can never be pushed while full. RST gating keeps the
  // request low while reset is asserted.
  assign occ = {1'b0, count_q} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign req = RST & ~ifq.redirect & (occ < (CW+1)'(DEPTH));

  assign keep_cnt = count_q - CW'(pop);
  assign rd_next  = rd_ptr + PW'(pop);

  // Head registers are loaded with whatever entry will sit at the head
  // after this edge: an older stored entry if one survives the pop,
  // otherwise the instruction returning this cycle (bypassing storage).
  always_comb begin
    head_valid_n = 1'b0;
    head_data_n  = head_data;
    head_pc_n    = head_pc;
    if (!ifq.redirect) begin
      if (keep_cnt != '0) begin
        head_valid_n = 1'b1;
        head_data_n  = mem_data[rd_next];
        head_pc_n    = mem_pc[rd_next];
      end else if (push) begin
        head_valid_n = 1'b1;
        head_data_n  = ifq.imem_data;
        head_pc_n    = req_pc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc   <= '0;
      req_pc     <= '0;
      inflight   <= 1'b0;
      cancel     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
      head_pc    <= '0;
    end else begin
      head_valid <= head_valid_n;
      head_data  <= head_data_n;
      head_pc    <= head_pc_n;
      if (req) req_pc <= fetch_pc;
      if (ifq.redirect) begin
        fetch_pc <= ifq.redirect_addr;
        inflight <= 1'b0;
        cancel   <= 1'b1;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count_q  <= '0;
      end else begin
        cancel   <= 1'b0;
        inflight <= req;
        if (req)  fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
        if (push) wr_ptr   <= wr_ptr + PW'(1);
        if (pop)  rd_ptr   <= rd_ptr + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Entry storage needs no reset: head_valid/count gate every read.
  always_ff @(posedge CLK) begin
    if (push && !ifq.redirect) begin
      mem_data[wr_ptr] <= ifq.imem_data;
      mem_pc[wr_ptr]   <= req_pc;
    end
  end

  assign ifq.imem_req   = req;
  assign ifq.imem_addr  = fetch_pc;
  assign ifq.inst_valid = head_valid;
  assign ifq.inst_data  = head_data;
  assign ifq.inst_pc    = head_pc;
  assign ifq.count      = count_q;

  a_no_push_on_full : assert property (
    @(posedge CLK) disable iff (!RST)
      !(push && !pop && count_q == CW'(DEPTH)));

  a_valid_tracks_count : assert property (
    @(posedge CLK) disable iff (!RST)
      head_valid == (count_q != '0));

  a_count_bounded : assert property (
    @(posedge CLK) disable iff (!RST)
      count_q <= CW'(DEPTH));
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the decode/execute top.
- Owns the fetch PC and issues read requests to the synchronous instruction memory.
- Buffers returned 32-bit instructions, tagged with their PC, in a small FIFO.
- Presents them to decode over a valid/ready handshake; flushes on a jump/branch redirect from decode.

Parameters:
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 6, instruction memory word address width
- DEPTH, 4, queue entries (power of two, ≥2)

Ports:
- CLK  input  1  clock; all state updates on posedge
- RST  input  1  reset, asynchronous, active-low
- imem_req  output  1  read request to instruction memory this cycle
- imem_addr  output  ADDR_WIDTH  read address; valid when imem_req=1
- imem_data  input  DATA_WIDTH  read data; valid exactly one cycle after imem_req
- redirect  input  1  jump/branch taken; flush and refetch
- redirect_addr  input  ADDR_WIDTH  new fetch PC when redirect=1
- inst_valid  output  1  head entry valid
- inst_ready  input  1  decode accepts head entry
- inst_data  output  DATA_WIDTH  head instruction
- inst_pc  output  ADDR_WIDTH  address of head instruction
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (RST=0, asynchronous):
  - fetch_pc=0, queue empty, count=0, in-flight flag=0.
  - imem_req=0, inst_valid=0, inst_data=0, inst_pc=0.
  - A reset during any operation discards queue contents and in-flight data.
- pop = inst_valid & inst_ready.
- push = in-flight flag set AND the request was not cancelled by a redirect.
  - imem_data and the PC of the request are written at the tail at the posedge ending the return cycle.
- Request rule:
  - imem_req = !redirect & (count + inflight − pop < DEPTH), evaluated combinationally.
  - imem_addr = fetch_pc.
  - When a request issues, fetch_pc increments by 1 and wraps from 2^ADDR_WIDTH−1 to 0.
  - The in-flight flag is set for the next cycle.
- Latency: instruction fetched in cycle N → imem_data in N+1 → inst_valid/inst_data/inst_pc visible in N+2. inst_data/inst_pc are registered FIFO head outputs.
- Throughput: with inst_ready held at 1, one instruction per cycle in steady state; the queue never overflows.
- Push and pop in the same cycle: both take effect and count is unchanged. This is legal at count=DEPTH only through the −pop term in the request rule.
- Pop on empty: impossible, since inst_valid=0.
- Push on full: forbidden by the credit rule. An assertion must fire if it occurs.
- Redirect, in the cycle it is high:
  - fetch_pc ← redirect_addr; no request issued.
  - The queue is cleared at the posedge (count=0).
  - Any in-flight return arriving next cycle is dropped, tracked by a cancel bit set on redirect.
  - Next cycle the request for redirect_addr issues; its instruction appears 2 cycles later.
  - inst_valid=0 from the cycle after redirect until then.
- Redirect together with pop: the pop is honoured (decode consumed the jump) and the flush takes precedence for all other state.
- Redirect on consecutive cycles: the last one wins; each cancels its predecessor.
- inst_valid must not depend combinationally on inst_ready.
- Once inst_valid=1, inst_data/inst_pc are stable until pop or redirect.

Test Plan:
- Startup: release RST with inst_ready=1 and memory word k = 0x1000_0000+k → imem_addr 0,1,2,… every cycle; first inst_valid 2 cycles after the first req with inst_pc=0, inst_data=0x1000_0000; then one instruction per cycle in order.
- Backpressure: hold inst_ready=0 → exactly 4 requests issue (addr 0–3), count saturates at 4, imem_req=0 while full; release inst_ready → pcs 0,1,2,3,4… delivered with no gap or duplicate.
- Redirect flush: at count=3 with a fetch of addr 5 in flight, pulse redirect with redirect_addr=0x28 → count=0 next cycle, addr-5 data dropped, next inst_pc=0x28 with its memory word, then 0x29.
- Wrap-around: redirect_addr=62 → inst_pc sequence 62,63,0,1.
- Redirect with pop: inst_valid=1, inst_ready=1, redirect=1 in the same cycle → head counted consumed exactly once and queue empty; next delivered inst_pc=redirect_addr.
- Reset mid-run: assert RST low while count=2 with a fetch in flight → outputs zero immediately (asynchronously); after release, fetch restarts at addr 0 and no stale data appears.
